// File: rtl/pp_piarb_wrr_sched.sv
// Weighted round-robin scheduler draining per-PP metadata FIFOs into one
// credit-paced PI-arbiter descriptor stream (one descriptor per cycle max).
module pp_piarb_wrr_sched #(
  parameter int unsigned NUM_PP     = 4,
  parameter int unsigned PP_NBITS   = 2,
  parameter int unsigned CREDITS    = 8,
  parameter int unsigned CRED_NBITS = 4,
  parameter int unsigned WT_NBITS   = 4,
  parameter int unsigned META_NBITS = 32
) (
  input  logic                                 clk,
  input  logic                                 rstn,
  input  logic [NUM_PP-1:0]                    pp_empty,
  input  logic [NUM_PP-1:0][META_NBITS-1:0]    pp_meta,
  output logic [NUM_PP-1:0]                    pp_rd,
  input  logic [NUM_PP-1:0]                    cfg_en,
  input  logic [NUM_PP*WT_NBITS-1:0]           cfg_weight,
  output logic                                 piarb_valid,
  output logic [META_NBITS-1:0]                piarb_meta,
  output logic [PP_NBITS-1:0]                  piarb_src,
  input  logic                                 piarb_credit_rtn,
  output logic [CRED_NBITS-1:0]                credit_cnt,
  output logic                                 credit_ovf
);

  logic [PP_NBITS-1:0]   ptr_q, ptr_d;
  logic [WT_NBITS-1:0]   burst_q, burst_d;
  logic [CRED_NBITS-1:0] credit_q, credit_d;
  logic                  ovf_q, ovf_d;
  logic                  valid_q, valid_d;
  logic [META_NBITS-1:0] meta_q, meta_d;
  logic [PP_NBITS-1:0]   src_q, src_d;

  logic [NUM_PP-1:0]     elig;
  logic [WT_NBITS-1:0]   eff_wt [NUM_PP];
  logic                  cand;
  logic [PP_NBITS-1:0]   sel;
  logic [PP_NBITS-1:0]   idx;
  logic                  issue;
  logic [WT_NBITS-1:0]   nb;

  assign elig = cfg_en & ~pp_empty;

  always_comb begin
    for (int unsigned i = 0; i < NUM_PP; i++) begin
      eff_wt[i] = cfg_weight[i*WT_NBITS +: WT_NBITS];
      if (eff_wt[i] == '0) eff_wt[i] = WT_NBITS'(1);
    end
  end

  // The pointer requester keeps the grant while its burst lasts; the
  // fallback scan deliberately excludes ptr itself (offsets 1..NUM_PP-1).
  always_comb begin
    cand = 1'b0;
    sel  = '0;
    idx  = '0;
    if (elig[ptr_q] && (burst_q < eff_wt[ptr_q])) begin
      cand = 1'b1;
      sel  = ptr_q;
    end else begin
      for (int unsigned k = 1; k < NUM_PP; k++) begin
        idx = PP_NBITS'(32'(ptr_q) + k);
        if (!cand && elig[idx]) begin
          cand = 1'b1;
          sel  = idx;
        end
      end
    end
  end

  assign issue = cand && (credit_q != '0);

  always_comb begin
    pp_rd = '0;
    if (issue && rstn) pp_rd[sel] = 1'b1;
  end

  always_comb begin
    if (sel == ptr_q) nb = (burst_q == '1) ? burst_q : burst_q + WT_NBITS'(1);
    else              nb = WT_NBITS'(1);
  end

  always_comb begin
    ptr_d   = ptr_q;
    burst_d = burst_q;
    if (issue) begin
      if (nb >= eff_wt[sel]) begin
        ptr_d   = sel + PP_NBITS'(1);
        burst_d = '0;
      end else begin
        ptr_d   = sel;
        burst_d = nb;
      end
    end
  end

  always_comb begin
    credit_d = credit_q;
    ovf_d    = ovf_q;
    case ({issue, piarb_credit_rtn})
      2'b10: credit_d = credit_q - CRED_NBITS'(1);
      2'b01: begin
        if (credit_q == CRED_NBITS'(CREDITS)) ovf_d = 1'b1;
        else                                  credit_d = credit_q + CRED_NBITS'(1);
      end
      default: credit_d = credit_q;
    endcase
  end

  always_comb begin
    valid_d = issue;
    meta_d  = meta_q;
    src_d   = src_q;
    if (issue) begin
      meta_d = pp_meta[sel];
      src_d  = sel;
    end
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      ptr_q    <= '0;
      burst_q  <= '0;
      credit_q <= CRED_NBITS'(CREDITS);
      ovf_q    <= 1'b0;
      valid_q  <= 1'b0;
      meta_q   <= '0;
      src_q    <= '0;
    end else begin
      ptr_q    <= ptr_d;
      burst_q  <= burst_d;
      credit_q <= credit_d;
      ovf_q    <= ovf_d;
      valid_q  <= valid_d;
      meta_q   <= meta_d;
      src_q    <= src_d;
    end
  end

  assign piarb_valid = valid_q;
  assign piarb_meta  = meta_q;
  assign piarb_src   = src_q;
  assign credit_cnt  = credit_q;
  assign credit_ovf  = ovf_q;

endmodule

// File: tb/tb_pp_piarb_wrr_sched.sv
// Self-checking bench for pp_piarb_wrr_sched: table of grant-order vectors
// plus hand-written credit, re-enable and reset-mid-burst sequences.
module tb_pp_piarb_wrr_sched;

  logic              clk = 1'b0;
  logic              rstn;
  logic [3:0]        pp_empty;
  logic [3:0][31:0]  pp_meta;
  logic [3:0]        pp_rd;
  logic [3:0]        cfg_en;
  logic [15:0]       cfg_weight;
  logic              piarb_valid;
  logic [31:0]       piarb_meta;
  logic [1:0]        piarb_src;
  logic              piarb_credit_rtn;
  logic [3:0]        credit_cnt;
  logic              credit_ovf;

  always #5 clk = ~clk;

  pp_piarb_wrr_sched #(
    .NUM_PP(4), .PP_NBITS(2), .CREDITS(8), .CRED_NBITS(4), .WT_NBITS(4), .META_NBITS(32)
  ) dut (
    .clk(clk), .rstn(rstn), .pp_empty(pp_empty), .pp_meta(pp_meta), .pp_rd(pp_rd),
    .cfg_en(cfg_en), .cfg_weight(cfg_weight), .piarb_valid(piarb_valid),
    .piarb_meta(piarb_meta), .piarb_src(piarb_src), .piarb_credit_rtn(piarb_credit_rtn),
    .credit_cnt(credit_cnt), .credit_ovf(credit_ovf)
  );

  // FIFO model: depth remaining and read index per requester; head = {id, index}.
  int unsigned cnt [4];
  int unsigned rdi [4];
  always_comb begin
    for (int i = 0; i < 4; i++) begin
      pp_empty[i] = (cnt[i] == 0);
      pp_meta[i]  = {8'(i), 24'(rdi[i])};
    end
  end

  int n_pass = 0;
  int n_tot  = 0;
  logic [1:0]  got_src [$];
  logic [31:0] got_meta [$];

  typedef struct packed {
    logic [15:0]      wt;
    logic [3:0]       en;
    logic [3:0][7:0]  depth;
    logic             exact;
    logic [4:0]       nexp;
    logic [15:0][1:0] src;
  } vec_t;

  vec_t vecs [3];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_tot++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
  endtask

  task automatic cycle();
    logic [3:0]  rd_s, emp_s, c_s;
    logic [31:0] m_s;
    logic [1:0]  i_s;
    #1;
    rd_s = pp_rd; emp_s = pp_empty; c_s = credit_cnt; m_s = '0; i_s = '0;
    for (int i = 0; i < 4; i++) if (rd_s[i]) begin m_s = pp_meta[i]; i_s = 2'(i); end
    @(posedge clk);
    #1;
    for (int i = 0; i < 4; i++) if (rd_s[i]) begin cnt[i]--; rdi[i]++; end
    @(negedge clk);
    chk("rd_onehot0", 64'($onehot0(rd_s)), 1);
    chk("rd_to_empty", 64'(rd_s & emp_s), 0);
    if (rd_s != 0) chk("rd_without_credit", 64'(c_s != 0), 1);
    chk("valid_latency", 64'(piarb_valid), 64'(rd_s != 0));
    if (piarb_valid) begin
      chk("src_vs_rd", 64'(piarb_src), 64'(i_s));
      chk("meta_vs_head", 64'(piarb_meta), 64'(m_s));
      got_src.push_back(piarb_src);
      got_meta.push_back(piarb_meta);
    end
  endtask

  task automatic load(input logic [15:0] wt, input logic [3:0] en,
                      input logic [3:0][7:0] depth, input logic rtn);
    rstn = 1'b0;
    cfg_weight = wt; cfg_en = en; piarb_credit_rtn = rtn;
    for (int i = 0; i < 4; i++) begin cnt[i] = depth[i]; rdi[i] = 0; end
    cycle();
    rstn = 1'b1;
    got_src.delete();
    got_meta.delete();
  endtask

  initial begin
    int pos;
    // Source sequences are listed highest index first; index 0 is rightmost.
    vecs[0] = '{wt: 16'h1111, en: 4'hF, depth: {8'd3, 8'd3, 8'd3, 8'd3}, exact: 1'b1,
                nexp: 5'd12, src: {2'd0,2'd0,2'd0,2'd0, 2'd3,2'd2,2'd1,2'd0,
                                   2'd3,2'd2,2'd1,2'd0, 2'd3,2'd2,2'd1,2'd0}};
    vecs[1] = '{wt: 16'h2013, en: 4'hF, depth: {8'd40, 8'd40, 8'd40, 8'd40}, exact: 1'b0,
                nexp: 5'd14, src: {2'd0,2'd0, 2'd3,2'd3,2'd2,2'd1,2'd0,2'd0,2'd0,
                                   2'd3,2'd3,2'd2,2'd1,2'd0,2'd0,2'd0}};
    vecs[2] = '{wt: 16'h1114, en: 4'b1011, depth: {8'd10, 8'd10, 8'd10, 8'd2}, exact: 1'b0,
                nexp: 5'd8, src: {2'd0,2'd0,2'd0,2'd0,2'd0,2'd0,2'd0,2'd0,
                                  2'd3,2'd1,2'd3,2'd1,2'd3,2'd1,2'd0,2'd0}};

    rstn = 1'b0; cfg_en = '0; cfg_weight = '0; piarb_credit_rtn = 1'b0;
    for (int i = 0; i < 4; i++) begin cnt[i] = 0; rdi[i] = 0; end

    // Reset then idle with all FIFOs empty.
    load(16'h1111, 4'hF, '0, 1'b0);
    for (int c = 0; c < 20; c++) begin
      cycle();
      chk("idle_rd", 64'(pp_rd), 0);
      chk("idle_valid", 64'(piarb_valid), 0);
      chk("idle_credit", 64'(credit_cnt), 8);
      chk("idle_ovf", 64'(credit_ovf), 0);
    end

    for (int v = 0; v < 3; v++) begin
      load(vecs[v].wt, vecs[v].en, vecs[v].depth, 1'b1);
      for (int c = 0; c < 40; c++) begin
        cycle();
        if (!vecs[v].exact && got_src.size() >= int'(vecs[v].nexp)) break;
      end
      if (vecs[v].exact) chk($sformatf("vec%0d_count", v), 64'(got_src.size()), 64'(vecs[v].nexp));
      else chk($sformatf("vec%0d_enough", v), 64'(got_src.size() >= int'(vecs[v].nexp)), 1);
      for (int k = 0; k < int'(vecs[v].nexp); k++)
        if (k < got_src.size())
          chk($sformatf("vec%0d_src%0d", v, k), 64'(got_src[k]), 64'(vecs[v].src[k]));
    end

    // Re-enable FIFO2 after the skip vector: serviced within one rotation.
    cfg_en = 4'hF;
    got_src.delete(); got_meta.delete();
    pos = -1;
    for (int c = 0; c < 10 && pos < 0; c++) begin
      cycle();
      foreach (got_src[k]) if (pos < 0 && got_src[k] == 2'd2) pos = k;
    end
    chk("reenable_seen", 64'(pos >= 0), 1);
    chk("reenable_within_rotation", 64'(pos < 4), 1);

    // Credit exhaustion and single-credit return.
    load(16'h1111, 4'hF, {8'd20, 8'd20, 8'd20, 8'd20}, 1'b0);
    for (int c = 0; c < 15; c++) cycle();
    chk("exhaust_issues", 64'(got_src.size()), 8);
    chk("exhaust_credit", 64'(credit_cnt), 0);
    chk("exhaust_rd", 64'(pp_rd), 0);
    piarb_credit_rtn = 1'b1;
    cycle();
    chk("rtn_credit", 64'(credit_cnt), 1);
    chk("rtn_no_same_cycle_issue", 64'(piarb_valid), 0);
    piarb_credit_rtn = 1'b0;
    chk("rtn_rd_pending", 64'(pp_rd != 0), 1);
    cycle();
    chk("one_issue_valid", 64'(piarb_valid), 1);
    chk("one_issue_credit", 64'(credit_cnt), 0);
    chk("one_issue_rd_off", 64'(pp_rd), 0);

    // Simultaneous issue and return, then overflow.
    load(16'h1111, 4'hF, {8'd20, 8'd20, 8'd20, 8'd20}, 1'b0);
    for (int c = 0; c < 10 && credit_cnt != 4'd5; c++) cycle();
    chk("reach_credit5", 64'(credit_cnt), 5);
    chk("credit5_rd_pending", 64'(pp_rd != 0), 1);
    piarb_credit_rtn = 1'b1;
    cycle();
    chk("simul_credit", 64'(credit_cnt), 5);
    chk("simul_valid", 64'(piarb_valid), 1);
    cfg_en = 4'h0;
    for (int c = 0; c < 3; c++) cycle();
    chk("refill_credit", 64'(credit_cnt), 8);
    chk("refill_no_ovf", 64'(credit_ovf), 0);
    cycle();
    chk("ovf_credit_hold", 64'(credit_cnt), 8);
    chk("ovf_set", 64'(credit_ovf), 1);
    piarb_credit_rtn = 1'b0;
    for (int c = 0; c < 3; c++) cycle();
    chk("ovf_sticky", 64'(credit_ovf), 1);
    chk("ovf_credit_after", 64'(credit_cnt), 8);

    // Reset mid-burst (burst_cnt=2 on FIFO0 with weight 4).
    load(16'h1114, 4'hF, {8'd20, 8'd20, 8'd20, 8'd20}, 1'b1);
    for (int c = 0; c < 5 && got_src.size() < 2; c++) cycle();
    chk("pre_reset_count", 64'(got_src.size()), 2);
    if (got_src.size() >= 2) begin
      chk("pre_reset_src0", 64'(got_src[0]), 0);
      chk("pre_reset_src1", 64'(got_src[1]), 0);
    end
    rstn = 1'b0;
    #1;
    chk("reset_rd_forced", 64'(pp_rd), 0);
    cycle();
    chk("reset_valid", 64'(piarb_valid), 0);
    chk("reset_credit", 64'(credit_cnt), 8);
    chk("reset_ovf", 64'(credit_ovf), 0);
    rstn = 1'b1;
    got_src.delete(); got_meta.delete();
    for (int c = 0; c < 10 && got_src.size() < 5; c++) cycle();
    chk("post_reset_count", 64'(got_src.size()), 5);
    for (int k = 0; k < 5; k++)
      if (k < got_src.size()) chk($sformatf("post_reset_src%0d", k), 64'(got_src[k]), (k < 4) ? 0 : 1);
    if (got_meta.size() > 0) chk("post_reset_meta0", 64'(got_meta[0]), 64'({8'd0, 24'd2}));

    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end

endmodule
